// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM port-2 arbiter.
// Covers FSM states, byte enables and the sub-word merge helper.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      MERGE,
      RESP
   } state_t;

   typedef logic [3:0] be_t;

   localparam be_t BE_FULL = 4'hF;
   localparam be_t BE_NONE = 4'h0;

   function automatic logic [31:0] merge_word(
      input logic [31:0] old_w,
      input logic [31:0] new_w,
      input be_t         be
   );
      logic [31:0] w;
      w = old_w;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            w[8*i +: 8] = new_w[8*i +: 8];
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant.
// rr_last remembers the previous winner; reset prefers requester 0.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] grant,
   output logic       gnt_id
);

   logic rr_last;

   always_comb begin
      gnt_id = 1'b0;
      grant  = 2'b00;
      unique case (1'b1)
         (req == 2'b11): gnt_id = ~rr_last;
         (req == 2'b01): gnt_id = 1'b0;
         (req == 2'b10): gnt_id = 1'b1;
         default:        gnt_id = 1'b0;
      endcase
      if (req != 2'b00) begin
         grant = gnt_id ? 2'b10 : 2'b01;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_last <= 1'b1;
      end else if (update) begin
         rr_last <= gnt_id;
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares RAM port 2 between the LSU (m0) and debug loader (m1).
// Sub-word stores become read-modify-write; out-of-range skips the RAM.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned MEM_SIZE = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_req,
   output logic        m0_ready,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [3:0]  m0_be,
   input  logic [31:0] m0_wdata,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_req,
   output logic        m1_ready,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [3:0]  m1_be,
   input  logic [31:0] m1_wdata,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic [31:0] ram_addr,
   output logic        ram_we,
   output logic [31:0] ram_wd,
   input  logic [31:0] ram_rd
);

   localparam logic [31:0] ADDR_MAX = 32'(MEM_SIZE - 4);

   state_t      state;
   logic        owner;
   logic        we_q;
   be_t         be_q;
   logic [31:0] wdata_q;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        m0_rv;
   logic        m1_rv;

   logic [1:0]  grant;
   logic        gnt_id;
   logic        hs;
   logic        sel_we;
   be_t         sel_be;
   logic [31:0] sel_wdata;
   logic [31:0] sel_raw;
   logic [31:0] sel_addr;

   rr_arbiter2 u_rr (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    ({m1_req, m0_req}),
      .update (hs),
      .grant  (grant),
      .gnt_id (gnt_id)
   );

   // Grants only surface in IDLE and never while reset is held.
   assign m0_ready = grant[0] & (state == IDLE) & rst_n;
   assign m1_ready = grant[1] & (state == IDLE) & rst_n;
   assign hs       = m0_ready | m1_ready;

   assign sel_we    = gnt_id ? m1_we    : m0_we;
   assign sel_be    = gnt_id ? m1_be    : m0_be;
   assign sel_wdata = gnt_id ? m1_wdata : m0_wdata;
   assign sel_raw   = gnt_id ? m1_addr  : m0_addr;
   assign sel_addr  = sel_raw & ~32'h3;

   assign m0_rvalid = m0_rv;
   assign m1_rvalid = m1_rv;
   assign m0_rdata  = m0_rv ? rsp_data : 32'h0;
   assign m1_rdata  = m1_rv ? rsp_data : 32'h0;
   assign m0_err    = m0_rv & rsp_err;
   assign m1_err    = m1_rv & rsp_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner    <= 1'b0;
         we_q     <= 1'b0;
         be_q     <= BE_NONE;
         wdata_q  <= 32'h0;
         rsp_data <= 32'h0;
         rsp_err  <= 1'b0;
         m0_rv    <= 1'b0;
         m1_rv    <= 1'b0;
         ram_addr <= 32'h0;
         ram_we   <= 1'b0;
         ram_wd   <= 32'h0;
      end else begin
         m0_rv  <= 1'b0;
         m1_rv  <= 1'b0;
         ram_we <= 1'b0;
         unique case (state)
            IDLE: begin
               if (hs) begin
                  owner   <= gnt_id;
                  we_q    <= sel_we;
                  be_q    <= sel_be;
                  wdata_q <= sel_wdata;
                  if (sel_addr > ADDR_MAX) begin
                     rsp_err  <= 1'b1;
                     rsp_data <= 32'h0;
                     m0_rv    <= ~gnt_id;
                     m1_rv    <= gnt_id;
                     state    <= RESP;
                  end else begin
                     rsp_err  <= 1'b0;
                     ram_addr <= sel_addr;
                     state    <= ACCESS;
                     if (sel_we && sel_be == BE_FULL) begin
                        ram_we <= 1'b1;
                        ram_wd <= sel_wdata;
                     end
                  end
               end
            end
            ACCESS: begin
               unique case (1'b1)
                  !we_q: begin
                     rsp_data <= ram_rd;
                     m0_rv    <= ~owner;
                     m1_rv    <= owner;
                     state    <= RESP;
                  end
                  we_q && (be_q == BE_FULL || be_q == BE_NONE): begin
                     rsp_data <= 32'h0;
                     m0_rv    <= ~owner;
                     m1_rv    <= owner;
                     state    <= RESP;
                  end
                  default: begin
                     ram_wd <= merge_word(ram_rd, wdata_q, be_q);
                     ram_we <= 1'b1;
                     state  <= MERGE;
                  end
               endcase
            end
            MERGE: begin
               rsp_data <= 32'h0;
               m0_rv    <= ~owner;
               m1_rv    <= owner;
               state    <= RESP;
            end
            RESP: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural RAM.
// Directed transactions push expected responses; a monitor pops them.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        m0_req = 1'b0, m1_req = 1'b0;
   logic        m0_we = 1'b0, m1_we = 1'b0;
   logic [31:0] m0_addr = '0, m1_addr = '0;
   logic [3:0]  m0_be = '0, m1_be = '0;
   logic [31:0] m0_wdata = '0, m1_wdata = '0;
   logic        m0_ready, m1_ready;
   logic        m0_rvalid, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_err, m1_err;
   logic [31:0] ram_addr, ram_wd, ram_rd;
   logic        ram_we;

   logic [31:0] mem [0:1023];
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int we_cnt = 0;
   int we_cyc = -1;

   typedef struct {
      int          m;
      logic [31:0] d;
      logic        e;
      int          c;
   } exp_t;
   exp_t q[$];
   exp_t me;

   ram_port_arbiter #(.MEM_SIZE(4096)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_ready(m0_ready), .m0_we(m0_we),
      .m0_addr(m0_addr), .m0_be(m0_be), .m0_wdata(m0_wdata),
      .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_ready(m1_ready), .m1_we(m1_we),
      .m1_addr(m1_addr), .m1_be(m1_be), .m1_wdata(m1_wdata),
      .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wd(ram_wd),
      .ram_rd(ram_rd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   assign ram_rd = mem[ram_addr[11:2]];
   always @(posedge clk) if (ram_we) mem[ram_addr[11:2]] <= ram_wd;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (ram_we) begin
         we_cnt++;
         we_cyc = cyc;
      end
      if (rst_n && (m0_rvalid || m1_rvalid)) begin
         if (m0_rvalid && m1_rvalid) begin
            chk("both_rvalid", 32'(m1_rvalid), 32'(0));
         end
         if (q.size() == 0) begin
            chk("unexpected_rvalid", {m1_rvalid, m0_rvalid}, 0);
         end else begin
            me = q.pop_front();
            chk("owner", 32'(m1_rvalid), 32'(me.m));
            chk("rdata", m1_rvalid ? m1_rdata : m0_rdata, me.d);
            chk("err", 32'(m1_rvalid ? m1_err : m0_err), 32'(me.e));
            chk("latency_cycle", 32'(cyc), 32'(me.c));
         end
      end
   end

   task automatic drive(input int m, input logic r, input logic we,
                        input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd);
      if (m == 0) begin
         m0_req = r; m0_we = we; m0_addr = a; m0_be = be; m0_wdata = wd;
      end else begin
         m1_req = r; m1_we = we; m1_addr = a; m1_be = be; m1_wdata = wd;
      end
   endtask

   task automatic issue(input int m, input logic we, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] erd, input logic eerr,
                        input int lat, input bit push, output int t);
      int n;
      logic rdy;
      exp_t e;
      n = 0;
      t = -1;
      drive(m, 1'b1, we, a, be, wd);
      forever begin
         #1;
         rdy = (m == 0) ? m0_ready : m1_ready;
         if (rdy || n >= 50) break;
         @(negedge clk);
         n++;
      end
      if (!rdy) begin
         chk("ready_timeout", 32'(m), 32'(-1));
         drive(m, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
         return;
      end
      t = cyc;
      if (push) begin
         e.m = m; e.d = erd; e.e = eerr; e.c = t + lat;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      drive(m, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         chk("response_timeout", 32'(q.size()), 0);
         q.delete();
      end
      @(negedge clk);
   endtask

   int t, t0, t1, wc;

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[4]    = 32'hDEADBEEF;
      mem[12]   = 32'hAABBCCDD;
      mem[16]   = 32'h11111111;
      mem[17]   = 32'h22222222;
      mem[18]   = 32'h33333333;
      mem[19]   = 32'h44444444;
      mem[20]   = 32'h01020304;
      mem[24]   = 32'h60606060;
      mem[25]   = 32'h64646464;
      mem[28]   = 32'h55AA55AA;
      mem[1023] = 32'hCAFEF00D;

      drive(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
      repeat (3) @(negedge clk);
      chk("rst_m0_ready", 32'(m0_ready), 0);
      chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
      chk("rst_ram_we", 32'(ram_we), 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_wd", ram_wd, 0);
      drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      issue(0, 0, 32'h10, 4'h0, 0, 32'hDEADBEEF, 0, 2, 1, t);
      wait_done();

      wc = we_cnt;
      issue(1, 1, 32'h20, 4'hF, 32'h12345678, 0, 0, 2, 1, t);
      wait_done();
      chk("full_we_count", 32'(we_cnt - wc), 1);
      chk("full_we_cycle", 32'(we_cyc), 32'(t + 1));
      chk("full_mem", mem[8], 32'h12345678);
      issue(0, 0, 32'h20, 4'h0, 0, 32'h12345678, 0, 2, 1, t);
      wait_done();

      wc = we_cnt;
      issue(0, 1, 32'h30, 4'b0010, 32'h0000EE00, 0, 0, 3, 1, t);
      wait_done();
      chk("part_mem", mem[12], 32'hAABBEEDD);
      chk("part_we_cycle", 32'(we_cyc), 32'(t + 2));
      chk("part_we_count", 32'(we_cnt - wc), 1);

      wc = we_cnt;
      issue(1, 1, 32'h71, 4'h0, 32'hFFFFFFFF, 0, 0, 2, 1, t);
      wait_done();
      chk("be0_mem", mem[28], 32'h55AA55AA);
      chk("be0_we_count", 32'(we_cnt - wc), 0);

      fork
         begin
            issue(0, 0, 32'h40, 4'h0, 0, 32'h11111111, 0, 2, 1, t0);
            issue(0, 0, 32'h48, 4'h0, 0, 32'h33333333, 0, 2, 1, t0);
         end
         begin
            issue(1, 0, 32'h44, 4'h0, 0, 32'h22222222, 0, 2, 1, t1);
            issue(1, 0, 32'h4C, 4'h0, 0, 32'h44444444, 0, 2, 1, t1);
         end
      join
      wait_done();
      chk("rr_last_order", 32'(t1 > t0), 1);

      wc = we_cnt;
      issue(1, 0, 32'h1000, 4'h0, 0, 32'h0, 1, 1, 1, t);
      wait_done();
      issue(1, 1, 32'h1000, 4'hF, 32'hBAD0BAD0, 32'h0, 1, 1, 1, t);
      wait_done();
      chk("oor_no_we", 32'(we_cnt - wc), 0);
      issue(1, 0, 32'hFFE, 4'h0, 0, 32'hCAFEF00D, 0, 2, 1, t);
      wait_done();

      issue(0, 1, 32'h50, 4'b0001, 32'h000000FF, 0, 0, 3, 0, t);
      @(negedge clk);
      @(negedge clk);
      chk("merge_we_high", 32'(ram_we), 1);
      rst_n = 1'b0;
      #1;
      chk("rst_we_drop", 32'(ram_we), 0);
      chk("rst_ready_low", {m1_ready, m0_ready}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_mem_kept", mem[20], 32'h01020304);

      fork
         issue(0, 0, 32'h60, 4'h0, 0, 32'h60606060, 0, 2, 1, t0);
         issue(1, 0, 32'h64, 4'h0, 0, 32'h64646464, 0, 2, 1, t1);
      join
      wait_done();
      chk("post_rst_m0_first", 32'(t1 > t0), 1);
      chk("queue_empty", 32'(q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
